demux1to4_stream: RTL and testbench

- Registered 1-to-4 stream demultiplexer; the distribution end of the 4-to-1 mux select path.
- Each accepted input word is routed by a 2-bit select to one of four output channels a/b/c/d.
- Each channel holds its word in a one-entry register with a valid/ready handshake.
- Each channel keeps a saturating count of delivered words.

---
 rtl/mux_pkg.sv | 12 +
 rtl/demux_out_slot.sv | 45 ++++
 rtl/demux1to4_stream.sv | 57 +++++
 tb/tb_demux1to4_stream.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the mux/demux stream family: channel count and
// select encodings, which match the mux select {s1,s0}.
package mux_pkg;

    localparam int unsigned NUM_CH = 4;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/demux_out_slot.sv
// One output channel: a one-entry word register with a valid/ready
// handshake and a saturating count of delivered words.
module demux_out_slot #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          ready,
    input  logic          count_clr,
    output logic [DW-1:0] data,
    output logic          valid,
    output logic [CW-1:0] count
);

    logic drain;

    assign drain = valid & ready;

    // A load in the same cycle as a drain keeps valid high for back-to-back flow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count_clr) begin
            count <= '0;
        end else if (drain && (count != '1)) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: each accepted word is steered by
// in_sel into one of four single-entry output slots.
module demux1to4_stream
    import mux_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NUM_CH*DW-1:0] out_data,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [NUM_CH*CW-1:0] count,
    input  logic                 count_clr
);

    logic              accept;
    logic [NUM_CH-1:0] load_sel;

    // Combinational through-path: the selected slot is free or draining now.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        load_sel = '0;
        case (in_sel)
            SEL_A:   load_sel[0] = accept;
            SEL_B:   load_sel[1] = accept;
            SEL_C:   load_sel[2] = accept;
            SEL_D:   load_sel[3] = accept;
            default: load_sel    = '0;
        endcase
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_out_slot #(
            .DW(DW),
            .CW(CW)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load_sel[k]),
            .load_data(in_data),
            .ready    (out_ready[k]),
            .count_clr(count_clr),
            .data     (out_data[k*DW +: DW]),
            .valid    (out_valid[k]),
            .count    (count[k*CW +: CW])
        );
    end

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed self-checking bench for demux1to4_stream.
module tb_demux1to4_stream;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] count;
    logic        count_clr;

    int unsigned passed;
    int unsigned total;

    demux1to4_stream #(
        .DW(8),
        .CW(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count),
        .count_clr(count_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        count_clr = 1'b0;

        #3;
        check("rst_out_valid", {28'd0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_count", count, 32'h0);
        check("rst_in_ready", {31'd0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Single word to c, drained immediately.
        out_ready = 4'b1111;
        in_data   = 8'hA5;
        in_sel    = 2'b10;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        check("c_valid", {28'd0, out_valid}, 32'h4);
        check("c_data", {24'd0, out_data[23:16]}, 32'hA5);
        step();
        check("c_drained", {28'd0, out_valid}, 32'h0);
        check("c_count", count, 32'h0001_0000);

        // Stall on b: second word must wait, then flow back-to-back.
        out_ready = 4'b1101;
        in_sel    = 2'b01;
        in_data   = 8'h11;
        in_valid  = 1'b1;
        check("b_ready_empty", {31'd0, in_ready}, 32'h1);
        step();
        in_data = 8'h22;
        check("b_ready_full", {31'd0, in_ready}, 32'h0);
        step();
        check("b_hold_data", {24'd0, out_data[15:8]}, 32'h11);
        step();
        check("b_hold_data2", {24'd0, out_data[15:8]}, 32'h11);
        check("b_hold_valid", {28'd0, out_valid}, 32'h2);
        out_ready = 4'b1111;
        #1;
        check("b_ready_drain", {31'd0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        check("b_second_data", {24'd0, out_data[15:8]}, 32'h22);
        check("b_second_valid", {28'd0, out_valid}, 32'h2);
        check("b_count_1", count, 32'h0001_0100);
        step();
        check("b_count_2", count, 32'h0001_0200);
        check("b_empty", {28'd0, out_valid}, 32'h0);

        // Back-to-back stream to d.
        in_sel   = 2'b11;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(i);
            #1;
            check("d_ready", {31'd0, in_ready}, 32'h1);
            step();
            check("d_data", {23'd0, out_valid[3], out_data[31:24]}, 32'h100 | 32'(i));
        end
        in_valid = 1'b0;
        step();
        check("d_count", count, 32'h0801_0200);

        // a stalled; switching in_sel steers the pending word to b instead.
        out_ready = 4'b1110;
        in_sel    = 2'b00;
        in_data   = 8'h3C;
        in_valid  = 1'b1;
        step();
        in_data = 8'h77;
        check("a_full_ready", {31'd0, in_ready}, 32'h0);
        step();
        check("a_hold", {23'd0, out_valid[0], out_data[7:0]}, 32'h13C);
        in_sel = 2'b01;
        #1;
        check("switch_ready", {31'd0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        check("switch_b_data", {23'd0, out_valid[1], out_data[15:8]}, 32'h177);
        check("switch_a_kept", {23'd0, out_valid[0], out_data[7:0]}, 32'h13C);

        // Saturate counter a.
        out_ready = 4'b1111;
        in_sel    = 2'b00;
        in_valid  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        check("a_saturated", {24'd0, count[7:0]}, 32'hFF);
        check("b_count_3", {24'd0, count[15:8]}, 32'h03);
        check("a_last_data", {23'd0, out_valid[0], out_data[7:0]}, 32'h12B);
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        check("clr_over_drain", count, 32'h0);
        check("clr_drained", {28'd0, out_valid}, 32'h0);

        // Fill all four slots, then reset asynchronously.
        in_sel   = 2'b10;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("pre_rst_count", count, 32'h0001_0000);
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel = 2'b00; in_data = 8'hA1; step();
        in_sel = 2'b01; in_data = 8'hB2; step();
        in_sel = 2'b10; in_data = 8'hC3; step();
        in_sel = 2'b11; in_data = 8'hD4; step();
        in_valid = 1'b0;
        check("all_full_valid", {28'd0, out_valid}, 32'hF);
        check("all_full_data", out_data, 32'hD4C3_B2A1);
        check("all_full_ready", {31'd0, in_ready}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {28'd0, out_valid}, 32'h0);
        check("async_rst_count", count, 32'h0);
        check("async_rst_data", out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
